// File: rtl/channel_packet_arbiter_pkg.sv
// Shared constants, state encoding and width helper
// for the channel packet arbiter.
package channel_arb_pkg;

  localparam int NUM_CH_DEF    = 8;
  localparam int DATA_W_DEF    = 16;
  localparam int PKT_WORDS_DEF = 128;

  localparam logic [15:0] HEADER_WORD_DEF = 16'hDEAD;
  localparam logic [15:0] ENDER_WORD_DEF  = 16'hBEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  function automatic int CH_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/channel_packet_arbiter_picker.sv
// Round-robin priority picker: first requester found
// scanning upward from rr_ptr, wrapping at NUM_CH.
module rr_priority_picker
  import channel_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CW     = CH_ID_W(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CW-1:0]     rr_ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CW-1:0]     gnt_idx_o,
  output logic              any_o
);

  // Scan from the pointer; the first set request bit wins
  always_comb begin
    int          k;
    logic [CW-1:0] kk;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k  = (int'(rr_ptr_i) + i) % NUM_CH;
      kk = k[CW-1:0];
      if (!any_o && req_i[kk]) begin
        any_o     = 1'b1;
        gnt_idx_o = kk;
      end
    end
    if (any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/channel_packet_arbiter.sv
// Round-robin packet read scheduler: grants one FIFO,
// reads a whole packet, forwards it with tags.
module channel_packet_arbiter
  import channel_arb_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PKT_WORDS = PKT_WORDS_DEF,
  parameter logic [DATA_W-1:0] HEADER_WORD =
    DATA_W'(HEADER_WORD_DEF),
  parameter logic [DATA_W-1:0] ENDER_WORD =
    DATA_W'(ENDER_WORD_DEF),
  localparam int CW = CH_ID_W(NUM_CH),
  localparam int NW = $clog2(PKT_WORDS) + 1
) (
  input  logic                     inclk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        FIFO_ready_mask,
  input  logic [NUM_CH*DATA_W-1:0] FIFO_rd_data,
  output logic [NUM_CH-1:0]        FIFO_rd_request,
  input  logic                     buf_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [CW-1:0]            out_ch_id,
  output logic                     pkt_err,
  output logic                     busy
);

  arb_state_e        state_q;
  logic [CW-1:0]     rr_ptr_q;
  logic [CW-1:0]     grant_q;
  logic [NUM_CH-1:0] grant_oh_q;
  logic [NW-1:0]     req_cnt_q;
  logic [NW-1:0]     rsp_cnt_q;
  logic              err_q;
  logic              rd_pend_q;
  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  logic [NUM_CH-1:0] pick_gnt;
  logic [CW-1:0]     pick_idx;
  logic              pick_any;
  logic              strobe;
  logic              last_req;
  logic              first_out;
  logic              last_out;
  logic [CW-1:0]     rr_next;
  logic [DATA_W-1:0] sel_word;

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_picker (
    .req_i     (FIFO_ready_mask),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Read strobe: granted FIFO has data, sink has room
  always_comb begin
    strobe = (state_q == ST_READ) && buf_ready
           && FIFO_ready_mask[grant_q]
           && (req_cnt_q < NW'(PKT_WORDS));
    last_req  = strobe
             && (req_cnt_q == NW'(PKT_WORDS - 1));
    first_out = vld_q && (rsp_cnt_q == '0);
    last_out  = vld_q
             && (rsp_cnt_q == NW'(PKT_WORDS - 1));
    rr_next   = (grant_q == CW'(NUM_CH - 1))
              ? '0 : grant_q + 1'b1;
    FIFO_rd_request = strobe ? grant_oh_q : '0;
  end

  // Select the granted channel's slice of the read bus
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CW'(i))
        sel_word = FIFO_rd_data[i*DATA_W +: DATA_W];
    end
  end

  // Grant FSM, counters, 2-stage data pipe, framing flag
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      vld_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      rd_pend_q <= strobe;
      vld_q     <= rd_pend_q;
      if (rd_pend_q) data_q <= sel_word;
      if (vld_q) rsp_cnt_q <= rsp_cnt_q + 1'b1;
      if (first_out && (data_q != HEADER_WORD))
        err_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (buf_ready && pick_any) begin
            grant_q    <= pick_idx;
            grant_oh_q <= pick_gnt;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          if (strobe) req_cnt_q <= req_cnt_q + 1'b1;
          if (last_req) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (rsp_cnt_q == NW'(PKT_WORDS)) begin
            rr_ptr_q  <= rr_next;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output tags decode straight from registered state
  always_comb begin
    out_data  = data_q;
    out_valid = vld_q;
    out_sop   = first_out;
    out_eop   = last_out;
    out_ch_id = grant_q;
    pkt_err   = last_out
             && (err_q || (data_q != ENDER_WORD));
    busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_channel_packet_arbiter.sv
// Self-checking bench for channel_packet_arbiter:
// FIFO models, packet scoreboard, rr grant model.
module tb_channel_packet_arbiter;
  import channel_arb_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int PW = 128;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  mask;
  logic [N*DW-1:0] rd_data;
  logic [N-1:0]  rd_req;
  logic          buf_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [CW-1:0] out_ch_id;
  logic          pkt_err, busy;

  always #5 clk = ~clk;

  channel_packet_arbiter dut (
    .inclk           (clk),
    .rst_n           (rst_n),
    .FIFO_ready_mask (mask),
    .FIFO_rd_data    (rd_data),
    .FIFO_rd_request (rd_req),
    .buf_ready       (buf_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_ch_id       (out_ch_id),
    .pkt_err         (pkt_err),
    .busy            (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic [15:0] hdr;
    logic [15:0] endr;
    int          id;
  } pkt_t;

  logic [DW-1:0] fq[N][$];
  pkt_t          expq[N][$];
  int            pkt_id = 0;
  logic [N-1:0]  en;

  function automatic logic [15:0] word(pkt_t p, int i);
    if (i == 0) return p.hdr;
    if (i == PW - 1) return p.endr;
    return {p.id[7:0], i[7:0]};
  endfunction

  task automatic load(input int ch, input logic [15:0] h,
                      input logic [15:0] e);
    pkt_t p;
    p.ch = ch; p.hdr = h; p.endr = e; p.id = pkt_id;
    pkt_id++;
    for (int i = 0; i < PW; i++) fq[ch].push_back(word(p, i));
    expq[ch].push_back(p);
  endtask

  // FIFO model: data valid the cycle after the strobe
  always @(posedge clk) begin
    for (int c = 0; c < N; c++)
      if (rd_req[c] && fq[c].size() != 0)
        rd_data[c*DW +: DW] <= fq[c].pop_front();
  end

  // Ready mask: FIFO holds data and channel enabled
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < N; c++)
      mask[c] = (fq[c].size() != 0) && en[c];
  end

  // Monitor / scoreboard state
  logic          busy_p = 1'b0;
  logic [N-1:0]  mask_p = '0;
  logic          br_p = 1'b0;
  int            ptr_m = 0, exp_grant = -1;
  int            in_cnt = 0, rx_ch = 0, bad_ch = 0;
  logic [15:0]   rx[PW];
  int            cyc = 0, strb_cnt = 0;
  int            strb_first = 0, strb_last = 0;
  int            idle_run = 0, vld_low = 0;
  int            gaps[$];
  int            order[$];
  int            eop_cnt = 0, last_eop_ch = -1;
  int            last_err = 0;
  pkt_t          mp;

  function automatic int rr_pick(logic [N-1:0] m, int ptr);
    for (int i = 0; i < N; i++)
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ptr_m = 0; busy_p = 1'b0; in_cnt = 0;
      exp_grant = -1; bad_ch = 0;
    end else begin
      cyc++;
      if (busy && !busy_p) begin
        exp_grant = rr_pick(mask_p, ptr_m);
        chk("grant_cond", int'(br_p && exp_grant >= 0), 1);
        gaps.push_back(idle_run);
        idle_run = 0;
        strb_cnt = 0;
      end
      if (!busy) idle_run++;
      if (rd_req != '0) begin
        chk("rd_req_legal",
            int'($onehot(rd_req) && ((rd_req & ~mask) == '0)
                 && buf_ready && busy), 1);
        if (strb_cnt == 0) strb_first = cyc;
        strb_last = cyc;
        strb_cnt++;
      end
      if (!buf_ready && out_valid) vld_low++;
      if (pkt_err) chk("pkt_err_at_eop", int'(out_eop), 1);
      if (out_valid) begin
        if (out_sop) begin
          chk("sop_pos", in_cnt, 0);
          chk("sop_ch", int'(out_ch_id), exp_grant);
          rx_ch = int'(out_ch_id);
          in_cnt = 0; bad_ch = 0;
          order.push_back(rx_ch);
        end else if (in_cnt == 0) begin
          chk("word_before_sop", 0, 1);
        end
        if (int'(out_ch_id) != rx_ch) bad_ch = 1;
        if (in_cnt < PW) rx[in_cnt] = out_data;
        in_cnt++;
        if (out_eop) begin
          chk("eop_len", in_cnt, PW);
          chk("ch_stable", bad_ch, 0);
          if (expq[rx_ch].size() == 0) begin
            chk("exp_pkt_avail", 0, 1);
          end else begin
            int mism;
            mp = expq[rx_ch].pop_front();
            mism = 0;
            for (int i = 0; i < PW; i++)
              if (rx[i] != word(mp, i)) mism++;
            chk("pkt_words", mism, 0);
            chk("pkt_err", int'(pkt_err),
                int'(mp.hdr != HEADER_WORD_DEF
                     || mp.endr != ENDER_WORD_DEF));
          end
          ptr_m = (rx_ch + 1) % N;
          last_eop_ch = rx_ch;
          last_err = int'(pkt_err);
          eop_cnt++;
          in_cnt = 0;
        end
      end else if (out_sop || out_eop || pkt_err) begin
        chk("tags_without_valid", 0, 1);
      end
      busy_p = busy; mask_p = mask; br_p = buf_ready;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int queued();
    int s = 0;
    for (int c = 0; c < N; c++)
      s += fq[c].size() + expq[c].size();
    return s;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || out_valid || queued() != 0) && n < budget) begin
      step(); n++;
    end
    chk("idle_timeout", int'(n < budget), 1);
  endtask

  task automatic wait_eop(input int target, input int budget,
                          input string name);
    int n = 0;
    while (eop_cnt < target && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, int'(eop_cnt >= target), 1);
    step();
  endtask

  task automatic wait_strb(input int target, input string name);
    int n = 0;
    while (strb_cnt < target && n < 1000) begin
      @(negedge clk); n++;
    end
    chk(name, int'(strb_cnt >= target), 1);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] hdr;
    logic [15:0] endr;
    int          exp_ch;
    int          exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int e0, s, loaded;
    tbl[0] = '{3, 16'hDEAD, 16'hBEEF, 3, 0};
    tbl[1] = '{5, 16'hDEAD, 16'h1234, 5, 1};
    tbl[2] = '{0, 16'h0000, 16'hBEEF, 0, 1};
    tbl[3] = '{6, 16'h0000, 16'h1234, 6, 1};
    tbl[4] = '{2, 16'hDEAD, 16'hBEEF, 2, 0};

    rst_n = 1'b0; buf_ready = 1'b0; en = '1;
    mask = '0; rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_flags",
        int'({out_valid, out_sop, out_eop, pkt_err, busy,
              out_ch_id, rd_req}), 0);
    step();
    rst_n = 1'b1; buf_ready = 1'b1;
    step();

    // Single-channel packets, framing variants
    foreach (tbl[r]) begin
      e0 = eop_cnt;
      load(tbl[r].ch, tbl[r].hdr, tbl[r].endr);
      wait_eop(e0 + 1, 1000, "tbl_eop_seen");
      chk("tbl_ch", last_eop_ch, tbl[r].exp_ch);
      chk("tbl_err", last_err, tbl[r].exp_err);
      chk("tbl_strobes", strb_cnt, PW);
      chk("tbl_strobe_span", strb_last - strb_first, PW - 1);
      wait_idle(200);
    end

    // Reset while idle, then three ready channels
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    order.delete(); gaps.delete();
    e0 = eop_cnt;
    load(0, 16'hDEAD, 16'hBEEF);
    load(0, 16'hDEAD, 16'hBEEF);
    load(1, 16'hDEAD, 16'hBEEF);
    load(7, 16'hDEAD, 16'hBEEF);
    wait_eop(e0 + 4, 2000, "rr_eop_seen");
    chk("rr_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 7);
      chk("rr_order3", order[3], 0);
    end
    chk("rr_gap_count", gaps.size(), 4);
    if (gaps.size() == 4)
      for (int g = 1; g < 4; g++) chk("rr_idle_gap", gaps[g], 1);
    wait_idle(200);

    // buf_ready low for 10 cycles mid-packet
    strb_cnt = 0;
    e0 = eop_cnt;
    load(4, 16'hDEAD, 16'hBEEF);
    wait_strb(40, "stall_reach");
    step();
    buf_ready = 1'b0; vld_low = 0; s = strb_cnt;
    repeat (10) @(negedge clk);
    chk("stall_no_strobe", strb_cnt, s);
    chk("stall_inflight_le2", int'(vld_low <= 2), 1);
    step();
    buf_ready = 1'b1;
    wait_eop(e0 + 1, 1000, "stall_eop_seen");
    chk("stall_ch", last_eop_ch, 4);
    wait_idle(200);

    // Granted channel drops ready while another waits
    strb_cnt = 0; order.delete();
    e0 = eop_cnt;
    load(2, 16'hDEAD, 16'hBEEF);
    wait_strb(50, "drop_reach");
    step();
    en[2] = 1'b0;
    load(5, 16'hDEAD, 16'hBEEF);
    s = strb_cnt;
    repeat (5) @(negedge clk);
    chk("drop_no_strobe", strb_cnt, s);
    step();
    en[2] = 1'b1;
    wait_eop(e0 + 2, 1000, "drop_eop_seen");
    chk("drop_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("drop_first", order[0], 2);
      chk("drop_second", order[1], 5);
    end
    wait_idle(200);

    // Reset mid-packet, then rr restarts from ch0
    load(4, 16'hDEAD, 16'hBEEF);
    begin
      int n = 0;
      while (in_cnt < 60 && n < 1000) begin
        @(negedge clk); n++;
      end
      chk("abort_reach", int'(in_cnt >= 60), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_flags",
        int'({out_valid, out_sop, out_eop, pkt_err, busy,
              out_ch_id, rd_req}), 0);
    fq[4].delete(); expq[4].delete();
    repeat (2) step();
    rst_n = 1'b1;
    order.delete();
    e0 = eop_cnt;
    load(1, 16'hDEAD, 16'hBEEF);
    load(6, 16'hDEAD, 16'hBEEF);
    wait_eop(e0 + 2, 1000, "abort_eop_seen");
    chk("abort_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("abort_first", order[0], 1);
      chk("abort_second", order[1], 6);
    end
    wait_idle(200);

    // Random traffic with stalls and ready dropouts
    loaded = 0;
    for (int t = 0; t < 9000; t++) begin
      if (loaded == 12 && !busy && !out_valid && queued() == 0)
        break;
      buf_ready = ($urandom_range(0, 9) < 8);
      en = N'($urandom | $urandom | $urandom);
      if (loaded < 12 && $urandom_range(0, 29) == 0) begin
        load($urandom_range(0, N - 1),
             ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'hDEAD,
             ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'hBEEF);
        loaded++;
      end
      step();
    end
    en = '1; buf_ready = 1'b1;
    wait_idle(2000);
    chk("rand_loaded", loaded, 12);
    chk("rand_remaining", queued(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
